// File: rtl/tomasulo_rs_param_if.sv
// Reservation-station bus bundle.
// Groups the flush, CDB broadcast, dispatch, issue and status signals of
// tomasulo_rs_param.
//   master : drives flush/CDB/dispatch/iss_accept; observes issue and status.
//   slave  : the reservation station itself.
// The parameters must match those of the reservation station it connects to.
interface tomasulo_rs_param_if #(
  parameter int unsigned ENTRIES_N = 4,
  parameter int unsigned W         = 32,
  parameter int unsigned TAG_W     = 4,
  parameter int unsigned OP_W      = 4
);
  localparam int unsigned OCC_W = $clog2(ENTRIES_N + 1);

  logic             flush;
  logic             cdb_vld;
  logic [TAG_W-1:0] cdb_tag;
  logic [W-1:0]     cdb_wdata;

  logic             dis_vld;
  logic             dis_accept;
  logic [OP_W-1:0]  dis_op;
  logic [TAG_W-1:0] dis_tag;
  logic             dis_src1_rdy;
  logic             dis_src0_rdy;
  logic [TAG_W-1:0] dis_src1_tag;
  logic [TAG_W-1:0] dis_src0_tag;
  logic [W-1:0]     dis_src1_data;
  logic [W-1:0]     dis_src0_data;

  logic             iss_vld_r;
  logic             iss_accept;
  logic [OP_W-1:0]  iss_op_r;
  logic [TAG_W-1:0] iss_tag_r;
  logic [W-1:0]     iss_src1_r;
  logic [W-1:0]     iss_src0_r;

  logic [OCC_W-1:0] occ_r;
  logic             full_r;
  logic             empty_r;

  modport master (
    output flush, cdb_vld, cdb_tag, cdb_wdata,
    output dis_vld, dis_op, dis_tag, dis_src1_rdy, dis_src0_rdy,
    output dis_src1_tag, dis_src0_tag, dis_src1_data, dis_src0_data,
    output iss_accept,
    input  dis_accept, iss_vld_r, iss_op_r, iss_tag_r, iss_src1_r, iss_src0_r,
    input  occ_r, full_r, empty_r
  );

  modport slave (
    input  flush, cdb_vld, cdb_tag, cdb_wdata,
    input  dis_vld, dis_op, dis_tag, dis_src1_rdy, dis_src0_rdy,
    input  dis_src1_tag, dis_src0_tag, dis_src1_data, dis_src0_data,
    input  iss_accept,
    output dis_accept, iss_vld_r, iss_op_r, iss_tag_r, iss_src1_r, iss_src0_r,
    output occ_r, full_r, empty_r
  );
endinterface

// File: rtl/tomasulo_rs_param.sv
// Parameterised Tomasulo reservation station with an issue-stage register.
// Instructions dispatch into the lowest free entry, wake up from the CDB
// (including a same-cycle dispatch bypass), and the oldest fully ready entry
// moves into the issue register whenever it is empty or being accepted.
// Ports:
//   clk   : clock, all state on the rising edge
//   rst_n : synchronous active-low reset
//   bus   : tomasulo_rs_param_if.slave (flush, CDB, dispatch, issue, status)
module tomasulo_rs_param #(
  parameter int unsigned ENTRIES_N = 4,
  parameter int unsigned W         = 32,
  parameter int unsigned TAG_W     = 4,
  parameter int unsigned OP_W      = 4
) (
  input logic               clk,
  input logic               rst_n,
  tomasulo_rs_param_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(ENTRIES_N);
  localparam int unsigned OCC_W = $clog2(ENTRIES_N + 1);

  logic [ENTRIES_N-1:0] valid_q, valid_d;
  logic [ENTRIES_N-1:0] s0_rdy_q, s0_rdy_d, s1_rdy_q, s1_rdy_d;
  logic [OP_W-1:0]      op_q      [ENTRIES_N];
  logic [OP_W-1:0]      op_d      [ENTRIES_N];
  logic [TAG_W-1:0]     tag_q     [ENTRIES_N];
  logic [TAG_W-1:0]     tag_d     [ENTRIES_N];
  logic [TAG_W-1:0]     s0_tag_q  [ENTRIES_N];
  logic [TAG_W-1:0]     s0_tag_d  [ENTRIES_N];
  logic [TAG_W-1:0]     s1_tag_q  [ENTRIES_N];
  logic [TAG_W-1:0]     s1_tag_d  [ENTRIES_N];
  logic [W-1:0]         s0_data_q [ENTRIES_N];
  logic [W-1:0]         s0_data_d [ENTRIES_N];
  logic [W-1:0]         s1_data_q [ENTRIES_N];
  logic [W-1:0]         s1_data_d [ENTRIES_N];
  // older_q[j][i] set: entry j was dispatched before entry i.
  logic [ENTRIES_N-1:0] older_q   [ENTRIES_N];
  logic [ENTRIES_N-1:0] older_d   [ENTRIES_N];

  logic [OCC_W-1:0] occ_q, occ_d;
  logic             full_q, full_d, empty_q, empty_d;
  logic             iss_vld_q, iss_vld_d;
  logic [OP_W-1:0]  iss_op_q, iss_op_d;
  logic [TAG_W-1:0] iss_tag_q, iss_tag_d;
  logic [W-1:0]     iss_src0_q, iss_src0_d, iss_src1_q, iss_src1_d;

  logic [ENTRIES_N-1:0] elig, sel_oh;
  logic [IDX_W-1:0]     sel_idx, alloc_idx;
  logic                 dis_fire, xfer;

  assign bus.dis_accept = ~full_q & ~bus.flush;
  assign dis_fire       = bus.dis_vld & bus.dis_accept;

  // Only registered readiness counts: no same-cycle wake-and-select.
  assign elig = valid_q & s0_rdy_q & s1_rdy_q;
  assign xfer = (|elig) & (~iss_vld_q | bus.iss_accept) & ~bus.flush;

  always_comb begin
    alloc_idx = '0;
    // Descending scan so the lowest free index is the last one written.
    for (int i = ENTRIES_N - 1; i >= 0; i--) begin
      if (!valid_q[i]) alloc_idx = IDX_W'(i);
    end
  end

  // Oldest eligible entry: eligible and no other eligible entry is older.
  always_comb begin
    sel_oh  = '0;
    sel_idx = '0;
    for (int i = 0; i < ENTRIES_N; i++) begin
      logic blocked;
      blocked = 1'b0;
      for (int j = 0; j < ENTRIES_N; j++) begin
        if (j != i && elig[j] && older_q[j][i]) blocked = 1'b1;
      end
      sel_oh[i] = elig[i] & ~blocked;
    end
    for (int i = 0; i < ENTRIES_N; i++) begin
      if (sel_oh[i]) sel_idx = IDX_W'(i);
    end
  end

  always_comb begin
    valid_d   = valid_q;
    s0_rdy_d  = s0_rdy_q;
    s1_rdy_d  = s1_rdy_q;
    op_d      = op_q;
    tag_d     = tag_q;
    s0_tag_d  = s0_tag_q;
    s1_tag_d  = s1_tag_q;
    s0_data_d = s0_data_q;
    s1_data_d = s1_data_q;
    older_d   = older_q;

    for (int i = 0; i < ENTRIES_N; i++) begin
      if (bus.cdb_vld && valid_q[i] && !s0_rdy_q[i] && s0_tag_q[i] == bus.cdb_tag) begin
        s0_rdy_d[i]  = 1'b1;
        s0_data_d[i] = bus.cdb_wdata;
      end
      if (bus.cdb_vld && valid_q[i] && !s1_rdy_q[i] && s1_tag_q[i] == bus.cdb_tag) begin
        s1_rdy_d[i]  = 1'b1;
        s1_data_d[i] = bus.cdb_wdata;
      end
    end

    if (xfer) valid_d[sel_idx] = 1'b0;

    if (dis_fire) begin
      valid_d[alloc_idx]  = 1'b1;
      op_d[alloc_idx]     = bus.dis_op;
      tag_d[alloc_idx]    = bus.dis_tag;
      s0_tag_d[alloc_idx] = bus.dis_src0_tag;
      s1_tag_d[alloc_idx] = bus.dis_src1_tag;
      if (bus.dis_src0_rdy) begin
        s0_rdy_d[alloc_idx]  = 1'b1;
        s0_data_d[alloc_idx] = bus.dis_src0_data;
      end else begin
        // Bypass a broadcast that lands in the dispatch cycle.
        s0_rdy_d[alloc_idx]  = bus.cdb_vld && (bus.dis_src0_tag == bus.cdb_tag);
        s0_data_d[alloc_idx] = bus.cdb_wdata;
      end
      if (bus.dis_src1_rdy) begin
        s1_rdy_d[alloc_idx]  = 1'b1;
        s1_data_d[alloc_idx] = bus.dis_src1_data;
      end else begin
        s1_rdy_d[alloc_idx]  = bus.cdb_vld && (bus.dis_src1_tag == bus.cdb_tag);
        s1_data_d[alloc_idx] = bus.cdb_wdata;
      end
      // New entry is younger than every other entry.
      older_d[alloc_idx] = '0;
      for (int j = 0; j < ENTRIES_N; j++) begin
        if (IDX_W'(j) != alloc_idx) older_d[j][alloc_idx] = 1'b1;
      end
    end

    if (bus.flush) begin
      valid_d = '0;
      for (int j = 0; j < ENTRIES_N; j++) older_d[j] = '0;
    end
  end

  always_comb begin
    iss_vld_d  = iss_vld_q;
    iss_op_d   = iss_op_q;
    iss_tag_d  = iss_tag_q;
    iss_src0_d = iss_src0_q;
    iss_src1_d = iss_src1_q;
    if (xfer) begin
      iss_vld_d  = 1'b1;
      iss_op_d   = op_q[sel_idx];
      iss_tag_d  = tag_q[sel_idx];
      iss_src0_d = s0_data_q[sel_idx];
      iss_src1_d = s1_data_q[sel_idx];
    end else if (bus.iss_accept) begin
      iss_vld_d = 1'b0;
    end
    if (bus.flush) iss_vld_d = 1'b0;

    case ({dis_fire, xfer})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
    if (bus.flush) occ_d = '0;

    full_d  = (occ_d == OCC_W'(ENTRIES_N));
    empty_d = (occ_d == '0) && !iss_vld_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q   <= '0;
      iss_vld_q <= 1'b0;
      occ_q     <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      for (int j = 0; j < ENTRIES_N; j++) older_q[j] <= '0;
    end else begin
      valid_q   <= valid_d;
      iss_vld_q <= iss_vld_d;
      occ_q     <= occ_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      older_q   <= older_d;
    end
  end

  // Payloads are only meaningful under a valid bit, so they carry no reset.
  always_ff @(posedge clk) begin
    s0_rdy_q   <= s0_rdy_d;
    s1_rdy_q   <= s1_rdy_d;
    op_q       <= op_d;
    tag_q      <= tag_d;
    s0_tag_q   <= s0_tag_d;
    s1_tag_q   <= s1_tag_d;
    s0_data_q  <= s0_data_d;
    s1_data_q  <= s1_data_d;
    iss_op_q   <= iss_op_d;
    iss_tag_q  <= iss_tag_d;
    iss_src0_q <= iss_src0_d;
    iss_src1_q <= iss_src1_d;
  end

  assign bus.iss_vld_r  = iss_vld_q;
  assign bus.iss_op_r   = iss_op_q;
  assign bus.iss_tag_r  = iss_tag_q;
  assign bus.iss_src0_r = iss_src0_q;
  assign bus.iss_src1_r = iss_src1_q;
  assign bus.occ_r      = occ_q;
  assign bus.full_r     = full_q;
  assign bus.empty_r    = empty_q;
endmodule

// File: tb/tb_tomasulo_rs_param.sv
// Directed self-checking bench for tomasulo_rs_param (default parameters).
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.
module tb_tomasulo_rs_param;
  logic clk;
  logic rst_n;
  int   n_total;
  int   n_bad;

  tomasulo_rs_param_if #(.ENTRIES_N(4), .W(32), .TAG_W(4), .OP_W(4)) bus ();

  tomasulo_rs_param #(.ENTRIES_N(4), .W(32), .TAG_W(4), .OP_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.flush         = 1'b0;
    bus.cdb_vld       = 1'b0;
    bus.cdb_tag       = '0;
    bus.cdb_wdata     = '0;
    bus.dis_vld       = 1'b0;
    bus.dis_op        = '0;
    bus.dis_tag       = '0;
    bus.dis_src0_rdy  = 1'b0;
    bus.dis_src1_rdy  = 1'b0;
    bus.dis_src0_tag  = '0;
    bus.dis_src1_tag  = '0;
    bus.dis_src0_data = '0;
    bus.dis_src1_data = '0;
  endtask

  task automatic dispatch(input logic [3:0] op, input logic [3:0] tag,
                          input logic r0, input logic [3:0] t0, input logic [31:0] d0,
                          input logic r1, input logic [3:0] t1, input logic [31:0] d1);
    bus.dis_vld       = 1'b1;
    bus.dis_op        = op;
    bus.dis_tag       = tag;
    bus.dis_src0_rdy  = r0;
    bus.dis_src0_tag  = t0;
    bus.dis_src0_data = d0;
    bus.dis_src1_rdy  = r1;
    bus.dis_src1_tag  = t1;
    bus.dis_src1_data = d1;
  endtask

  task automatic cdb(input logic [3:0] tag, input logic [31:0] data);
    bus.cdb_vld   = 1'b1;
    bus.cdb_tag   = tag;
    bus.cdb_wdata = data;
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    idle_inputs();
    bus.iss_accept = 1'b1;
    rst_n = 1'b0;
    step();
    step();
    chk("rst_iss_vld", 64'(bus.iss_vld_r), 64'd0);
    chk("rst_occ",     64'(bus.occ_r),     64'd0);
    chk("rst_full",    64'(bus.full_r),    64'd0);
    chk("rst_empty",   64'(bus.empty_r),   64'd1);
    chk("rst_accept",  64'(bus.dis_accept), 64'd1);
    rst_n = 1'b1;

    // Basic all-ready dispatch: issue at t+2.
    dispatch(4'd3, 4'd5, 1'b1, 4'd0, 32'h10, 1'b1, 4'd0, 32'h20);
    step();
    idle_inputs();
    chk("basic_occ_t1",   64'(bus.occ_r),     64'd1);
    chk("basic_vld_t1",   64'(bus.iss_vld_r), 64'd0);
    chk("basic_empty_t1", 64'(bus.empty_r),   64'd0);
    step();
    chk("basic_vld_t2", 64'(bus.iss_vld_r),  64'd1);
    chk("basic_op",     64'(bus.iss_op_r),   64'd3);
    chk("basic_tag",    64'(bus.iss_tag_r),  64'd5);
    chk("basic_src0",   64'(bus.iss_src0_r), 64'h10);
    chk("basic_src1",   64'(bus.iss_src1_r), 64'h20);
    step();
    chk("basic_occ_t3",   64'(bus.occ_r),     64'd0);
    chk("basic_vld_t3",   64'(bus.iss_vld_r), 64'd0);
    chk("basic_empty_t3", 64'(bus.empty_r),   64'd1);

    // CDB wakeup two cycles after dispatch.
    dispatch(4'd1, 4'd1, 1'b0, 4'd7, 32'h0, 1'b1, 4'd0, 32'h1);
    step();
    idle_inputs();
    step();
    cdb(4'd7, 32'hABCD);
    step();
    idle_inputs();
    chk("wake_vld_b1", 64'(bus.iss_vld_r), 64'd0);
    step();
    chk("wake_vld_b2", 64'(bus.iss_vld_r),  64'd1);
    chk("wake_tag",    64'(bus.iss_tag_r),  64'd1);
    chk("wake_src0",   64'(bus.iss_src0_r), 64'hABCD);
    chk("wake_src1",   64'(bus.iss_src1_r), 64'h1);
    step();

    // Same-cycle dispatch bypass on src1.
    dispatch(4'd2, 4'd3, 1'b1, 4'd0, 32'h7, 1'b0, 4'd2, 32'h0);
    cdb(4'd2, 32'h55);
    step();
    idle_inputs();
    chk("byp_vld_t1", 64'(bus.iss_vld_r), 64'd0);
    step();
    chk("byp_vld_t2", 64'(bus.iss_vld_r),  64'd1);
    chk("byp_tag",    64'(bus.iss_tag_r),  64'd3);
    chk("byp_src1",   64'(bus.iss_src1_r), 64'h55);
    chk("byp_src0",   64'(bus.iss_src0_r), 64'h7);
    step();

    // Fill all four entries, one broadcast wakes all; issue in dispatch order.
    for (int k = 1; k <= 4; k++) begin
      dispatch(4'(k), 4'(k), 1'b0, 4'd9, 32'h0, 1'b1, 4'd0, 32'(k));
      step();
    end
    idle_inputs();
    #1;
    chk("fill_occ",    64'(bus.occ_r),      64'd4);
    chk("fill_full",   64'(bus.full_r),     64'd1);
    chk("fill_accept", 64'(bus.dis_accept), 64'd0);
    cdb(4'd9, 32'h900);
    step();
    idle_inputs();
    chk("fill_vld_w1", 64'(bus.iss_vld_r), 64'd0);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("fill_vld",  64'(bus.iss_vld_r),  64'd1);
      chk("fill_tag",  64'(bus.iss_tag_r),  64'(k));
      chk("fill_src0", 64'(bus.iss_src0_r), 64'h900);
      chk("fill_src1", 64'(bus.iss_src1_r), 64'(k));
      chk("fill_occ",  64'(bus.occ_r),      64'(4 - k));
      chk("fill_full", 64'(bus.full_r),     64'd0);
    end
    step();
    chk("fill_drain_vld",   64'(bus.iss_vld_r), 64'd0);
    chk("fill_drain_empty", 64'(bus.empty_r),   64'd1);

    // Age order independent of index: the reused entry 1 is the youngest.
    dispatch(4'd0, 4'd1, 1'b0, 4'd9,  32'h0, 1'b1, 4'd0, 32'h0);
    step();
    dispatch(4'd0, 4'd2, 1'b0, 4'd10, 32'h0, 1'b1, 4'd0, 32'h0);
    step();
    dispatch(4'd0, 4'd3, 1'b0, 4'd9,  32'h0, 1'b1, 4'd0, 32'h0);
    step();
    idle_inputs();
    cdb(4'd10, 32'h0);
    step();
    idle_inputs();
    step();
    chk("age_first_tag", 64'(bus.iss_tag_r), 64'd2);
    dispatch(4'd0, 4'd4, 1'b0, 4'd9, 32'h0, 1'b1, 4'd0, 32'h0);
    step();
    idle_inputs();
    cdb(4'd9, 32'h0);
    step();
    idle_inputs();
    step();
    chk("age_tag_a", 64'(bus.iss_tag_r), 64'd1);
    step();
    chk("age_tag_c", 64'(bus.iss_tag_r), 64'd3);
    step();
    chk("age_tag_d", 64'(bus.iss_tag_r), 64'd4);
    step();
    chk("age_drain", 64'(bus.iss_vld_r), 64'd0);

    // Back-pressure: issue register holds for five cycles.
    bus.iss_accept = 1'b0;
    dispatch(4'd5, 4'd5, 1'b1, 4'd0, 32'h11, 1'b1, 4'd0, 32'h22);
    step();
    dispatch(4'd6, 4'd6, 1'b1, 4'd0, 32'h33, 1'b1, 4'd0, 32'h44);
    step();
    idle_inputs();
    for (int k = 0; k < 5; k++) begin
      chk("stall_vld",  64'(bus.iss_vld_r),  64'd1);
      chk("stall_tag",  64'(bus.iss_tag_r),  64'd5);
      chk("stall_src0", 64'(bus.iss_src0_r), 64'h11);
      chk("stall_occ",  64'(bus.occ_r),      64'd1);
      step();
    end
    bus.iss_accept = 1'b1;
    step();
    chk("stall_next_tag",  64'(bus.iss_tag_r),  64'd6);
    chk("stall_next_src0", 64'(bus.iss_src0_r), 64'h33);
    chk("stall_next_occ",  64'(bus.occ_r),      64'd0);
    step();
    chk("stall_done_vld", 64'(bus.iss_vld_r), 64'd0);

    // Flush with three held entries, a busy issue register and a dispatch.
    bus.iss_accept = 1'b0;
    for (int k = 11; k <= 14; k++) begin
      dispatch(4'd1, 4'(k), 1'b1, 4'd0, 32'(k), 1'b1, 4'd0, 32'(k));
      step();
    end
    idle_inputs();
    chk("pre_flush_occ", 64'(bus.occ_r),     64'd3);
    chk("pre_flush_vld", 64'(bus.iss_vld_r), 64'd1);
    chk("pre_flush_tag", 64'(bus.iss_tag_r), 64'd11);
    bus.flush = 1'b1;
    dispatch(4'd1, 4'd15, 1'b1, 4'd0, 32'hF, 1'b1, 4'd0, 32'hF);
    cdb(4'd0, 32'h0);
    #1;
    chk("flush_accept", 64'(bus.dis_accept), 64'd0);
    step();
    idle_inputs();
    bus.iss_accept = 1'b1;
    chk("flush_occ",   64'(bus.occ_r),     64'd0);
    chk("flush_vld",   64'(bus.iss_vld_r), 64'd0);
    chk("flush_empty", 64'(bus.empty_r),   64'd1);
    chk("flush_full",  64'(bus.full_r),    64'd0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("flush_no_issue", 64'(bus.iss_vld_r), 64'd0);
    end

    // Reset mid-operation, then dispatch in the first cycle out of reset.
    dispatch(4'd2, 4'd8, 1'b1, 4'd0, 32'h8, 1'b1, 4'd0, 32'h8);
    step();
    idle_inputs();
    rst_n = 1'b0;
    step();
    chk("mid_rst_occ", 64'(bus.occ_r),     64'd0);
    chk("mid_rst_vld", 64'(bus.iss_vld_r), 64'd0);
    rst_n = 1'b1;
    dispatch(4'd4, 4'd7, 1'b1, 4'd0, 32'h70, 1'b1, 4'd0, 32'h71);
    step();
    idle_inputs();
    chk("post_rst_occ", 64'(bus.occ_r), 64'd1);
    step();
    chk("post_rst_vld",  64'(bus.iss_vld_r),  64'd1);
    chk("post_rst_tag",  64'(bus.iss_tag_r),  64'd7);
    chk("post_rst_src1", 64'(bus.iss_src1_r), 64'h71);
    step();
    chk("post_rst_drain", 64'(bus.iss_vld_r), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/tomasulo_rs_param.md
TOMASULO_RS_PARAM -- requirements
Module: tomasulo_rs_param

Interface
REQ-001 SHALL have parameter ENTRIES_N, default 4, number of reservation-station entries (legal 2..16).
REQ-002 SHALL have parameter W, default 32, operand/result word width.
REQ-003 SHALL have parameter TAG_W, default 4, producer-tag width.
REQ-004 SHALL have parameter OP_W, default 4, opcode width.
REQ-005 SHALL have ports, one per line (name, direction, width, meaning):
clk  in  1  single clock; all state updates on the rising edge.
rst_n  in  1  synchronous active-low reset.
flush  in  1  discard all held instructions.
cdb_vld  in  1  common data bus broadcast valid.
cdb_tag  in  TAG_W  producing tag.
cdb_wdata  in  W  broadcast result.
dis_vld  in  1  dispatch request.
dis_accept  out  1  dispatch can be taken; equals ~full_r & ~flush.
dis_op  in  OP_W  opcode.
dis_tag  in  TAG_W  destination tag of the dispatched instruction.
dis_src1_rdy, dis_src0_rdy  in  1 each  source operand already valid.
dis_src1_tag, dis_src0_tag  in  TAG_W each  producer tag when not ready.
dis_src1_data, dis_src0_data  in  W each  operand value when ready.
iss_vld_r  out  1  issue-stage register valid.
iss_accept  in  1  execution unit takes the issue register.
iss_op_r  out  OP_W  issued opcode.
iss_tag_r  out  TAG_W  issued destination tag.
iss_src1_r, iss_src0_r  out  W each  issued operand values.
occ_r  out  clog2(ENTRIES_N+1)  count of valid entries (excluding issue register).
full_r  out  1  occ_r == ENTRIES_N.
empty_r  out  1  occ_r == 0 and iss_vld_r == 0.

Function
REQ-006 Dispatch fires when dis_vld & dis_accept; the instruction is written into the lowest-index free entry and is valid from the next cycle.
REQ-007 full_r is registered; an entry freed in cycle t is not available for dispatch until cycle t+1.
REQ-008 Each entry holds valid, op, tag, and per source {rdy, tag, data}.
REQ-009 CDB wakeup: for every valid entry, each non-ready source with tag == cdb_tag while cdb_vld is set captures cdb_wdata and becomes ready at the next edge.
REQ-010 Dispatch bypass: a dispatched source with rdy=0 whose tag matches cdb_tag while cdb_vld is set in the same cycle is stored ready, with data = cdb_wdata.
REQ-011 An entry is eligible when valid and both sources are ready as registered state; there is no same-cycle wake-and-select.
REQ-012 Selection is oldest-first by dispatch order (age matrix or equivalent), independent of entry index.
REQ-013 Issue transfer occurs when at least one entry is eligible and (~iss_vld_r | iss_accept).
- The selected entry loads the iss_*_r registers and is freed at the same edge.
REQ-014 iss_vld_r clears when iss_accept is high and no transfer occurs.
- iss_*_r holds stable while iss_vld_r & ~iss_accept.
REQ-015 Minimum latency: dispatch of an all-ready instruction in cycle t -> iss_vld_r high in cycle t+2.
REQ-016 Simultaneous dispatch and transfer in one cycle: occ_r is unchanged.
- Otherwise occ_r changes by +1 per dispatch and -1 per transfer.
REQ-017 A single CDB broadcast wakes all matching sources in all entries in the same cycle, both src0 and src1 of one entry included.
REQ-018 flush high: at the next edge all entries invalidate, iss_vld_r=0, occ_r=0, and age state clears.
- Dispatch and transfer in the flush cycle are dropped.
- CDB in the flush cycle has no effect.
REQ-019 iss_tag_r/op/data contents are don't-care while iss_vld_r=0.
- Entry payloads need no reset.

Reset
REQ-020 While rst_n=0 at an edge: all entries invalid, iss_vld_r=0, occ_r=0, full_r=0, empty_r=1, and age state cleared; dis_accept is therefore 1 after reset (absent flush).
REQ-021 Reset asserted mid-operation discards all held and in-issue instructions with no partial output.
- First valid dispatch is possible in the first cycle with rst_n=1.

Verification
REQ-022 Dispatch op=3, tag=5, both rdy, src0=0x10, src1=0x20 at t, iss_accept=1 -> iss_vld_r=1 at t+2 with tag 5, src0 0x10, src1 0x20; occ_r back to 0 at t+3.
REQ-023 Dispatch tag 1 with src0 waiting on tag 7; cdb_vld tag 7 data 0xABCD two cycles later -> iss_vld_r two cycles after the broadcast, iss_src0_r=0xABCD.
REQ-024 Dispatch with src1 waiting on tag 2 while cdb_vld tag 2 data 0x55 in the same cycle -> stored ready; issue at t+2 with iss_src1_r=0x55.
REQ-025 ENTRIES_N=4: dispatch tags 1..4 with sources not ready, then wake in order 4,3,2,1 in the same cycle -> issue order 1,2,3,4; full_r=1 and dis_accept=0 while four entries are held.
REQ-026 iss_accept=0 for 5 cycles with iss_vld_r=1 -> iss_*_r stable; queued eligible entries remain; no loss or duplication.
REQ-027 flush with 3 entries and iss_vld_r=1, concurrent dis_vld -> next cycle occ_r=0, iss_vld_r=0, empty_r=1; the dropped dispatch never issues.
